// File: rtl/cur_buf_pkg.sv
// Shared constants and read-FSM state type for the current-block buffer controller.
package cur_buf_pkg;
   localparam int ROWS   = 16;
   localparam int ADDR_W = 4;
   localparam int IN_W   = 32;
   localparam int ROW_W  = 2 * IN_W;

   typedef enum logic [1:0] {
      RD_IDLE = 2'd0,
      RD_READ = 2'd1,
      RD_HOLD = 2'd2
   } rd_state_e;
endpackage

// File: rtl/cur_buf_ctrl_if.sv
// Fetch-stream, SRAM write/read port and ME-engine handshake bundle.
// slave = the controller, master = the surrounding fetch/ME/SRAM side.
interface cur_buf_ctrl_if #(
   parameter int IN_W   = cur_buf_pkg::IN_W,
   parameter int ADDR_W = cur_buf_pkg::ADDR_W
);
   logic              in_valid;
   logic [IN_W-1:0]   in_data;
   logic              in_ready;
   logic              wr_en;
   logic              wr_bank;
   logic [ADDR_W-1:0] wr_addr;
   logic [2*IN_W-1:0] wr_data;
   logic              me_req;
   logic              me_release;
   logic              me_grant;
   logic              rd_en;
   logic              rd_bank;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_vld;
   logic [1:0]        full;

   modport slave (
      input  in_valid, in_data, me_req, me_release,
      output in_ready, wr_en, wr_bank, wr_addr, wr_data,
             me_grant, rd_en, rd_bank, rd_addr, rd_vld, full
   );

   modport master (
      output in_valid, in_data, me_req, me_release,
      input  in_ready, wr_en, wr_bank, wr_addr, wr_data,
             me_grant, rd_en, rd_bank, rd_addr, rd_vld, full
   );
endinterface

// File: rtl/cur_buf_pack.sv
// Packs pairs of accepted fetch words into one SRAM row: first word low, second high.
// Row strobe is issued the cycle after the second word of a pair is accepted.
module cur_buf_pack #(
   parameter int IN_W = cur_buf_pkg::IN_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              acc_i,
   input  logic [IN_W-1:0]   data_i,
   output logic              pair_o,
   output logic [2*IN_W-1:0] row_o,
   output logic              row_vld_o
);
   import cur_buf_pkg::*;

   logic              phase_q;
   logic              vld_q;
   logic [2*IN_W-1:0] row_q;

   // Pair completes this cycle; phase only advances on accepted words, so bubbles keep pairing.
   assign pair_o    = acc_i & phase_q;
   assign row_o     = row_q;
   assign row_vld_o = vld_q;

   // Track pair phase, capture each word into its half and pulse the row strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= 1'b0;
         vld_q   <= 1'b0;
         row_q   <= '0;
      end else begin
         vld_q <= pair_o;
         if (acc_i) begin
            phase_q <= ~phase_q;
            if (phase_q) row_q[2*IN_W-1:IN_W] <= data_i;
            else         row_q[IN_W-1:0]      <= data_i;
         end
      end
   end
endmodule

// File: rtl/cur_buf_ctrl.sv
// Ping-pong current-block buffer controller: loads rows into the write bank while the
// ME engine reads the other bank. Full flags hand banks between writer and reader.
module cur_buf_ctrl #(
   parameter int ROWS = cur_buf_pkg::ROWS,
   parameter int IN_W = cur_buf_pkg::IN_W
) (
   input  logic          clk,
   input  logic          rst_n,
   cur_buf_ctrl_if.slave bus
);
   import cur_buf_pkg::*;

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(ROWS - 1);

   logic [ADDR_W-1:0] row_q, row_d;
   logic              wr_bank_q, wr_bank_d;
   logic [1:0]        full_q, full_d, full_set, full_clr;
   logic              acc, pair, strobe;
   rd_state_e         rd_st_q, rd_st_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              rd_bank_q, rd_bank_d, rd_vld_q;
   logic              grant, rel;

   // Gated by reset so the input side reads as not-ready while held in reset.
   assign bus.in_ready = rst_n & ~full_q[wr_bank_q];
   assign acc          = bus.in_valid & bus.in_ready;

   cur_buf_pack #(.IN_W(IN_W)) u_pack (
      .clk       (clk),
      .rst_n     (rst_n),
      .acc_i     (acc),
      .data_i    (bus.in_data),
      .pair_o    (pair),
      .row_o     (bus.wr_data),
      .row_vld_o (strobe)
   );

   assign bus.wr_en   = strobe;
   assign bus.wr_addr = row_q;
   assign bus.wr_bank = wr_bank_q;

   // Advance the write row after each strobe; the bank switches once its last row is written.
   always_comb begin
      row_d     = row_q;
      wr_bank_d = wr_bank_q;
      if (strobe) begin
         if (row_q == LAST) begin
            row_d     = '0;
            wr_bank_d = ~wr_bank_q;
         end else begin
            row_d = row_q + 1'b1;
         end
      end
   end

   // Full is raised as the last pair completes, so in_ready drops before any
   // further word can slip in during the final row strobe.
   assign full_set = {2{pair && (row_q == LAST)}} & (wr_bank_q ? 2'b10 : 2'b01);
   assign grant    = bus.me_req && (((rd_st_q == RD_IDLE) && full_q[rd_bank_q]) ||
                                    ((rd_st_q == RD_HOLD) && !bus.me_release));
   assign rel      = (rd_st_q == RD_HOLD) && bus.me_release;
   assign full_clr = {2{rel}} & (rd_bank_q ? 2'b10 : 2'b01);
   assign full_d   = (full_q & ~full_clr) | full_set;

   // Read pass sequencing: grant -> ROWS reads -> hold until release or re-read.
   always_comb begin
      rd_st_d   = rd_st_q;
      cnt_d     = cnt_q;
      rd_bank_d = rd_bank_q;
      case (rd_st_q)
         RD_IDLE: if (grant) rd_st_d = RD_READ;
         RD_READ: begin
            if (cnt_q == LAST) begin
               cnt_d   = '0;
               rd_st_d = RD_HOLD;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RD_HOLD: begin
            if (rel) begin
               rd_st_d   = RD_IDLE;
               rd_bank_d = ~rd_bank_q;
            end else if (grant) begin
               rd_st_d = RD_READ;
            end
         end
         default: rd_st_d = RD_IDLE;
      endcase
   end

   assign bus.me_grant = grant;
   assign bus.rd_en    = (rd_st_q == RD_READ);
   assign bus.rd_addr  = cnt_q;
   assign bus.rd_bank  = rd_bank_q;
   assign bus.rd_vld   = rd_vld_q;
   assign bus.full     = full_q;

   // State registers for write pointer, full flags and read FSM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_q     <= '0;
         wr_bank_q <= 1'b0;
         full_q    <= 2'b00;
         rd_st_q   <= RD_IDLE;
         cnt_q     <= '0;
         rd_bank_q <= 1'b0;
         rd_vld_q  <= 1'b0;
      end else begin
         row_q     <= row_d;
         wr_bank_q <= wr_bank_d;
         full_q    <= full_d;
         rd_st_q   <= rd_st_d;
         cnt_q     <= cnt_d;
         rd_bank_q <= rd_bank_d;
         rd_vld_q  <= (rd_st_q == RD_READ);
      end
   end
endmodule
